// File: rtl/first_down_counter.sv
// Loadable down-counter / countdown timer.
// Counts a loaded value down to terminal count; pulses tc_pulse, sets a sticky underflow flag and optionally auto-reloads.
module first_down_counter #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_underflow,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc_pulse,
    output logic             underflow_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             uf_q, uf_d;
    logic             uf_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            uf_q     <= uf_d;
        end
    end

    // Load beats counting; a zero load is an immediate terminal count.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        uf_set   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            if (load_value != '0) begin
                state_d = RUN;
            end else begin
                state_d = DONE;
                tc_d    = 1'b1;
                uf_set  = 1'b1;
            end
        end else if (state_q == RUN && enable) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                tc_d   = 1'b1;
                uf_set = 1'b1;
                if (AUTO_RELOAD != 0) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                end
            end
        end

        // A set on the same edge overrides a clear request.
        if (uf_set) begin
            uf_d = 1'b1;
        end else if (clear_underflow) begin
            uf_d = 1'b0;
        end else begin
            uf_d = uf_q;
        end
    end

    assign counter_out   = count_q;
    assign tc_pulse      = tc_q;
    assign underflow_out = uf_q;
    assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_first_down_counter.sv
// Self-checking bench for first_down_counter: table-driven vectors fed through an expected-result queue.
module tb_first_down_counter;

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic       clr;
        logic [7:0] lv;
        int         sel;
        logic [7:0] cnt;
        logic       tc;
        logic       uf;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, enable, load, clear_underflow;
    logic [7:0] load_value;

    logic [3:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic       tc_a, tc_b, tc_c, uf_a, uf_b, uf_c, busy_a, busy_b, busy_c;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   vec_idx   = 0;

    always #5 clk = ~clk;

    first_down_counter #(.WIDTH(4), .AUTO_RELOAD(0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value[3:0]), .clear_underflow(clear_underflow),
        .counter_out(cnt_a), .tc_pulse(tc_a), .underflow_out(uf_a), .busy(busy_a)
    );

    first_down_counter #(.WIDTH(4), .AUTO_RELOAD(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value[3:0]), .clear_underflow(clear_underflow),
        .counter_out(cnt_b), .tc_pulse(tc_b), .underflow_out(uf_b), .busy(busy_b)
    );

    first_down_counter #(.WIDTH(8), .AUTO_RELOAD(0)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value), .clear_underflow(clear_underflow),
        .counter_out(cnt_c), .tc_pulse(tc_c), .underflow_out(uf_c), .busy(busy_c)
    );

    task automatic add(input logic rst, input logic ld, input logic en, input logic clr,
                       input logic [7:0] lv, input int sel, input logic [7:0] cnt,
                       input logic tc, input logic uf, input logic bsy);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.clr = clr; v.lv = lv; v.sel = sel;
        v.cnt = cnt; v.tc = tc; v.uf = uf; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s vec %0d got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one vector's inputs and queue the outputs it should produce after the next edge.
    task automatic applyStimulus(input vec_t v);
        reset           = v.rst;
        load            = v.ld;
        enable          = v.en;
        clear_underflow = v.clr;
        load_value      = v.lv;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t       e;
        logic [7:0] a_cnt;
        logic       a_tc, a_uf, a_busy;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("[TB] FAIL scoreboard vec %0d got empty queue expected one entry", vec_idx);
            return;
        end
        e = exp_q.pop_front();
        case (e.sel)
            0:       begin a_cnt = {4'b0, cnt_a}; a_tc = tc_a; a_uf = uf_a; a_busy = busy_a; end
            1:       begin a_cnt = {4'b0, cnt_b}; a_tc = tc_b; a_uf = uf_b; a_busy = busy_b; end
            default: begin a_cnt = cnt_c;         a_tc = tc_c; a_uf = uf_c; a_busy = busy_c; end
        endcase
        compare("counter_out", vec_idx, a_cnt, e.cnt);
        compare("tc_pulse", vec_idx, {7'b0, a_tc}, {7'b0, e.tc});
        compare("underflow_out", vec_idx, {7'b0, a_uf}, {7'b0, e.uf});
        compare("busy", vec_idx, {7'b0, a_busy}, {7'b0, e.busy});
    endtask

    task automatic runVectors();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput();
            vec_idx++;
        end
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0; clear_underflow = 1'b0; load_value = 8'd0;
        @(posedge clk);
        #1;

        // rst ld en clr lv sel -> cnt tc uf busy
        // Reset holds against load/enable
        add(1,1,1,0, 7,0,  0,0,0,0);
        add(1,0,1,0, 0,0,  0,0,0,0);
        // Load 5, count to terminal, then hold in DONE
        add(0,1,0,0, 5,0,  5,0,0,1);
        add(0,0,1,0, 0,0,  4,0,0,1);
        add(0,0,1,0, 0,0,  3,0,0,1);
        add(0,0,1,0, 0,0,  2,0,0,1);
        add(0,0,1,0, 0,0,  1,0,0,1);
        add(0,0,1,0, 0,0,  0,1,1,0);
        add(0,0,1,0, 0,0,  0,0,1,0);
        add(0,0,1,0, 0,0,  0,0,1,0);
        // Load 6 (enable on the load edge ignored), pause at 3
        add(0,1,1,0, 6,0,  6,0,1,1);
        add(0,0,1,0, 0,0,  5,0,1,1);
        add(0,0,1,0, 0,0,  4,0,1,1);
        add(0,0,1,0, 0,0,  3,0,1,1);
        add(0,0,0,0, 0,0,  3,0,1,1);
        add(0,0,0,0, 0,0,  3,0,1,1);
        add(0,0,0,0, 0,0,  3,0,1,1);
        add(0,0,0,0, 0,0,  3,0,1,1);
        add(0,0,1,0, 0,0,  2,0,1,1);
        add(0,0,1,0, 0,0,  1,0,1,1);
        add(0,0,1,0, 0,0,  0,1,1,0);
        // Clear, then set-wins-over-clear at terminal count
        add(0,0,0,1, 0,0,  0,0,0,0);
        add(0,1,0,0, 4,0,  4,0,0,1);
        add(0,0,1,0, 0,0,  3,0,0,1);
        add(0,0,1,0, 0,0,  2,0,0,1);
        add(0,0,1,0, 0,0,  1,0,0,1);
        add(0,0,1,1, 0,0,  0,1,1,0);
        add(0,0,0,1, 0,0,  0,0,0,0);
        // Reload mid-run
        add(0,1,0,0, 4,0,  4,0,0,1);
        add(0,0,1,0, 0,0,  3,0,0,1);
        add(0,1,1,0, 9,0,  9,0,0,1);
        add(0,0,1,0, 0,0,  8,0,0,1);
        // Load 0 is an immediate terminal count
        add(0,1,1,0, 0,0,  0,1,1,0);
        add(0,0,1,0, 0,0,  0,0,1,0);
        // Reset mid-run clears everything; IDLE ignores enable
        add(0,1,0,0, 5,0,  5,0,1,1);
        add(0,0,1,0, 0,0,  4,0,1,1);
        add(1,1,1,0, 3,0,  0,0,0,0);
        add(0,0,1,0, 0,0,  0,0,0,0);
        // Auto-reload instance
        add(1,0,0,0, 0,1,  0,0,0,0);
        add(0,1,0,0, 3,1,  3,0,0,1);
        add(0,0,1,0, 0,1,  2,0,0,1);
        add(0,0,1,0, 0,1,  1,0,0,1);
        add(0,0,1,0, 0,1,  3,1,1,1);
        add(0,0,1,0, 0,1,  2,0,1,1);
        add(0,0,1,0, 0,1,  1,0,1,1);
        add(0,0,1,0, 0,1,  3,1,1,1);
        add(0,0,0,0, 0,1,  3,0,1,1);
        add(0,0,1,1, 0,1,  2,0,0,1);
        add(0,1,1,0, 0,1,  0,1,1,0);
        add(0,0,1,0, 0,1,  0,0,1,0);
        runVectors();

        // WIDTH=8: load 255 takes exactly 255 enabled edges to terminal count
        add(1,0,0,0, 0,2,  0,0,0,0);
        add(0,1,0,0, 255,2, 255,0,0,1);
        for (int i = 1; i <= 255; i++) begin
            add(0,0,1,0, 0,2, 8'(255 - i), (i == 255), (i == 255), (i != 255));
        end
        add(0,0,1,0, 0,2,  0,0,1,0);
        // WIDTH=8 reset mid-run
        add(0,1,0,0, 200,2, 200,0,1,1);
        add(0,0,1,0, 0,2,  199,0,1,1);
        add(1,0,1,0, 0,2,  0,0,0,0);
        runVectors();

        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
